// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - requester command buses, grants and SDRAM pin bundle for sdram_arbit
interface sdram_arbit_if;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;

    logic        aref_req;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;

    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;

    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;

    logic        aref_en;
    logic        wr_en;
    logic        rd_en;

    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM bus arbiter between init, refresh, write and read command sources
module sdram_arbit #(
    parameter logic [3:0]  NOP       = 4'b0111,
    parameter logic [1:0]  IDLE_BANK = 2'b11,
    parameter logic [12:0] IDLE_ADDR = 13'h1fff
) (
    input  logic         arb_clk,
    input  logic         arb_rst,
    sdram_arbit_if.slave bus
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        last_rd_q;
    logic        last_rd_d;

    logic [3:0]  cmd_sel;
    logic [1:0]  ba_sel;
    logic [12:0] addr_sel;
    logic        dq_oe;

    // last_rd resets high so that a write wins the very first write/read tie
    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            state_q   <= ST_INIT;
            last_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        case (state_q)
            ST_INIT: begin
                if (bus.init_end) begin
                    state_d = ST_ARBIT;
                end
            end
            ST_ARBIT: begin
                if (bus.aref_req) begin
                    state_d = ST_AREF;
                end else if (bus.wr_req && (!bus.rd_req || last_rd_q)) begin
                    state_d   = ST_WRITE;
                    last_rd_d = 1'b0;
                end else if (bus.rd_req) begin
                    state_d   = ST_READ;
                    last_rd_d = 1'b1;
                end
            end
            ST_AREF: begin
                if (bus.aref_end) begin
                    state_d = ST_ARBIT;
                end
            end
            ST_WRITE: begin
                if (bus.wr_end) begin
                    state_d = ST_ARBIT;
                end
            end
            ST_READ: begin
                if (bus.rd_end) begin
                    state_d = ST_ARBIT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // command source follows the registered state so the pins change one cycle after the decision
    always_comb begin
        cmd_sel  = bus.init_cmd;
        ba_sel   = bus.init_ba;
        addr_sel = bus.init_addr;
        case (state_q)
            ST_ARBIT: begin
                cmd_sel  = NOP;
                ba_sel   = IDLE_BANK;
                addr_sel = IDLE_ADDR;
            end
            ST_AREF: begin
                cmd_sel  = bus.aref_cmd;
                ba_sel   = bus.aref_ba;
                addr_sel = bus.aref_addr;
            end
            ST_WRITE: begin
                cmd_sel  = bus.wr_cmd;
                ba_sel   = bus.wr_ba;
                addr_sel = bus.wr_addr;
            end
            ST_READ: begin
                cmd_sel  = bus.rd_cmd;
                ba_sel   = bus.rd_ba;
                addr_sel = bus.rd_addr;
            end
            default: begin
                cmd_sel  = bus.init_cmd;
                ba_sel   = bus.init_ba;
                addr_sel = bus.init_addr;
            end
        endcase
    end

    assign dq_oe = bus.wr_sdram_en && (state_q == ST_WRITE);

    assign bus.aref_en      = (state_q == ST_AREF);
    assign bus.wr_en        = (state_q == ST_WRITE);
    assign bus.rd_en        = (state_q == ST_READ);

    assign bus.sdram_cke    = 1'b1;
    assign bus.sdram_cs_n   = cmd_sel[3];
    assign bus.sdram_ras_n  = cmd_sel[2];
    assign bus.sdram_cas_n  = cmd_sel[1];
    assign bus.sdram_we_n   = cmd_sel[0];
    assign bus.sdram_ba     = ba_sel;
    assign bus.sdram_addr   = addr_sel;
    assign bus.sdram_dq_oe  = dq_oe;
    assign bus.sdram_dq_out = dq_oe ? bus.wr_sdram_data : 16'd0;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed scenarios plus randomized traffic against a behavioural owner model
`timescale 1ns/1ps
module tb_sdram_arbit;

    logic arb_clk;
    logic arb_rst;
    sdram_arbit_if bus();

    sdram_arbit dut (
        .arb_clk (arb_clk),
        .arb_rst (arb_rst),
        .bus     (bus)
    );

    initial arb_clk = 1'b0;
    always #10 arb_clk = ~arb_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] grants();
        return {bus.aref_en, bus.wr_en, bus.rd_en};
    endfunction

    function automatic logic [18:0] pins();
        return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                bus.sdram_ba, bus.sdram_addr};
    endfunction

    localparam logic [18:0] IDLE_PINS = {4'b0111, 2'b11, 13'h1fff};

    // Model: has init finished, who owns the bus (0 none, 1 refresh, 2 write, 3 read),
    // and whether a write should win the next write/read tie.
    bit m_ready;
    int m_owner;
    bit m_prefer_wr;

    always @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            m_ready     <= 1'b0;
            m_owner     <= 0;
            m_prefer_wr <= 1'b1;
        end else if (!m_ready) begin
            if (bus.init_end) m_ready <= 1'b1;
        end else begin
            case (m_owner)
                0: begin
                    if (bus.aref_req) m_owner <= 1;
                    else if (bus.wr_req && (!bus.rd_req || m_prefer_wr)) begin
                        m_owner <= 2; m_prefer_wr <= 1'b0;
                    end else if (bus.rd_req) begin
                        m_owner <= 3; m_prefer_wr <= 1'b1;
                    end
                end
                1: if (bus.aref_end) m_owner <= 0;
                2: if (bus.wr_end)   m_owner <= 0;
                3: if (bus.rd_end)   m_owner <= 0;
                default: m_owner <= 0;
            endcase
        end
    end

    logic [18:0] exp_pins;
    logic [2:0]  exp_gr;
    logic        exp_oe;

    always @(negedge arb_clk) begin
        #2;
        exp_gr = {m_owner == 1, m_owner == 2, m_owner == 3};
        if (!m_ready)          exp_pins = {bus.init_cmd, bus.init_ba, bus.init_addr};
        else if (m_owner == 1) exp_pins = {bus.aref_cmd, bus.aref_ba, bus.aref_addr};
        else if (m_owner == 2) exp_pins = {bus.wr_cmd, bus.wr_ba, bus.wr_addr};
        else if (m_owner == 3) exp_pins = {bus.rd_cmd, bus.rd_ba, bus.rd_addr};
        else                   exp_pins = IDLE_PINS;
        exp_oe = (m_owner == 2) && bus.wr_sdram_en;
        check("cmp_grants", grants(), exp_gr);
        check("cmp_pins", {bus.sdram_cke, pins()}, {1'b1, exp_pins});
        check("cmp_dq", {bus.sdram_dq_oe, bus.sdram_dq_out},
              {exp_oe, exp_oe ? bus.wr_sdram_data : 16'd0});
    end

    task automatic step();
        @(negedge arb_clk);
    endtask

    bit seen;
    int init_wait;

    initial begin
        arb_rst = 1'b1;
        bus.init_end = 0; bus.init_cmd = 4'b0010; bus.init_ba = 2'b01; bus.init_addr = 13'h0400;
        bus.aref_req = 0; bus.aref_end = 0; bus.aref_cmd = 4'b0001; bus.aref_ba = 2'b10; bus.aref_addr = 13'h0aaa;
        bus.wr_req = 0; bus.wr_end = 0; bus.wr_cmd = 4'b0100; bus.wr_ba = 2'b10; bus.wr_addr = 13'h0123;
        bus.wr_sdram_en = 1; bus.wr_sdram_data = 16'h1234;
        bus.rd_req = 0; bus.rd_end = 0; bus.rd_cmd = 4'b0101; bus.rd_ba = 2'b00; bus.rd_addr = 13'h0456;

        repeat (2) step();
        #3;
        check("rst_grants", grants(), 3'b000);
        check("rst_oe_dq", {bus.sdram_dq_oe, bus.sdram_dq_out}, 17'd0);
        check("rst_cke", bus.sdram_cke, 1'b1);
        check("rst_pins", pins(), {4'b0010, 2'b01, 13'h0400});

        // write request held through a long init
        step(); arb_rst = 0; bus.wr_sdram_en = 0; bus.wr_req = 1;
        seen = 0;
        repeat (100) begin step(); #3; if (bus.wr_en) seen = 1; end
        check("init_hold_wr_en", seen, 1'b0);
        step(); bus.init_end = 1; #3;
        check("init_last_wr_en", bus.wr_en, 1'b0);
        step(); #3;
        check("arbit_wr_en", bus.wr_en, 1'b0);
        check("arbit_idle_pins", pins(), IDLE_PINS);
        step(); #3;
        check("wr_en_after_init", bus.wr_en, 1'b1);
        check("wr_pins", pins(), {4'b0100, 2'b10, 13'h0123});
        bus.wr_end = 1; bus.wr_req = 0;
        step(); bus.wr_end = 0; #3;
        check("wr_end_drop", grants(), 3'b000);

        // three-way tie straight after a fresh reset
        step(); arb_rst = 1;
        step(); arb_rst = 0; bus.aref_req = 1; bus.wr_req = 1; bus.rd_req = 1;
        step(); #3;
        check("tie3_arbit", grants(), 3'b000);
        step(); #3;
        check("tie3_aref_first", grants(), 3'b100);
        bus.aref_req = 0; bus.aref_end = 1;
        step(); bus.aref_end = 0; #3;
        check("tie3_gap1", grants(), 3'b000);
        step(); #3;
        check("tie3_wr_second", grants(), 3'b010);
        bus.wr_end = 1; bus.wr_req = 0;
        step(); bus.wr_end = 0; #3;
        check("tie3_gap2", grants(), 3'b000);
        step(); #3;
        check("tie3_rd_third", grants(), 3'b001);
        bus.wr_req = 1; bus.rd_end = 1;
        step(); bus.rd_end = 0;

        // alternation with a single idle cycle between grants
        for (int g = 0; g < 4; g++) begin
            #3;
            check("alt_idle_cycle", {grants(), pins()}, {3'b000, IDLE_PINS});
            step(); #3;
            check("alt_grant", grants(), (g % 2 == 0) ? 3'b010 : 3'b001);
            repeat (7) step();
            if (g % 2 == 0) bus.wr_end = 1; else bus.rd_end = 1;
            step(); bus.wr_end = 0; bus.rd_end = 0;
        end
        bus.rd_req = 0;

        // data path during a write
        step(); bus.wr_sdram_data = 16'hA5A5; bus.wr_sdram_en = 1; #3;
        check("dq_write_grant", grants(), 3'b010);
        check("dq_write_on", {bus.sdram_dq_oe, bus.sdram_dq_out}, {1'b1, 16'hA5A5});
        step(); bus.wr_sdram_en = 0; #3;
        check("dq_write_off", {bus.sdram_dq_oe, bus.sdram_dq_out}, 17'd0);
        bus.wr_end = 1; bus.wr_req = 0;
        step(); bus.wr_end = 0;

        // refresh request and stray write end during a read
        bus.rd_req = 1;
        step(); #3;
        check("rd_grant", grants(), 3'b001);
        bus.rd_req = 0; bus.aref_req = 1; bus.wr_end = 1; bus.wr_sdram_en = 1;
        step(); bus.wr_end = 0; #3;
        check("rd_ignores_wr_end", grants(), 3'b001);
        check("rd_no_oe", bus.sdram_dq_oe, 1'b0);
        step(); #3;
        check("rd_not_preempted", grants(), 3'b001);
        bus.rd_end = 1;
        step(); bus.rd_end = 0; #3;
        check("rd_end_gap", grants(), 3'b000);
        step(); #3;
        check("aref_after_rd", grants(), 3'b100);
        bus.aref_req = 0; bus.aref_end = 1;
        step(); bus.aref_end = 0; bus.wr_sdram_en = 0;

        // asynchronous reset in the middle of a read
        bus.rd_req = 1;
        step(); #3;
        check("rd_before_rst", grants(), 3'b001);
        #3 arb_rst = 1;
        #1;
        check("async_rst_grants", grants(), 3'b000);
        check("async_rst_pins", pins(), {4'b0010, 2'b01, 13'h0400});
        bus.init_end = 0;
        step(); step(); arb_rst = 0;
        step(); #3;
        check("post_rst_no_grant", grants(), 3'b000);
        step(); #3;
        check("post_rst_no_grant2", grants(), 3'b000);
        bus.init_end = 1;

        // randomized traffic, occasional resets
        init_wait = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (arb_rst) begin
                arb_rst = 0;
                init_wait = $urandom_range(0, 6);
            end else if ($urandom_range(0, 299) == 0) begin
                arb_rst = 1;
                bus.init_end = 0;
            end
            if (!arb_rst) begin
                if (init_wait > 0) init_wait--;
                bus.init_end = (init_wait == 0);
            end
            bus.aref_req = ($urandom_range(0, 4) == 0);
            bus.wr_req   = $urandom_range(0, 1);
            bus.rd_req   = $urandom_range(0, 1);
            bus.aref_end = ($urandom_range(0, 3) == 0);
            bus.wr_end   = ($urandom_range(0, 3) == 0);
            bus.rd_end   = ($urandom_range(0, 3) == 0);
            bus.init_cmd = 4'($urandom);  bus.init_ba = 2'($urandom);  bus.init_addr = 13'($urandom);
            bus.aref_cmd = 4'($urandom);  bus.aref_ba = 2'($urandom);  bus.aref_addr = 13'($urandom);
            bus.wr_cmd   = 4'($urandom);  bus.wr_ba   = 2'($urandom);  bus.wr_addr   = 13'($urandom);
            bus.rd_cmd   = 4'($urandom);  bus.rd_ba   = 2'($urandom);  bus.rd_addr   = 13'($urandom);
            bus.wr_sdram_en   = $urandom_range(0, 1);
            bus.wr_sdram_data = 16'($urandom);
        end

        step(); #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
